// File: rtl/trace_pkg.sv
// Shared types and constants for the control-signal trace buffer.
package trace_pkg;

  localparam int TRACE_W_DEF = 14;
  localparam int TS_W_DEF    = 16;

  typedef struct packed {
    logic [TS_W_DEF-1:0]    ts;
    logic [TRACE_W_DEF-1:0] word;
  } trace_entry_t;

  typedef enum logic [1:0] {
    ARMED = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2
  } trace_state_e;

  // Field order matches the datapath/controller bundle, MSB first.
  function automatic logic [TRACE_W_DEF-1:0] pack_ctrl(
    input logic       zero,
    input logic [1:0] pc_src,
    input logic [1:0] result_src,
    input logic       mem_write,
    input logic       alu_src,
    input logic [2:0] alu_control,
    input logic [2:0] imm_src,
    input logic       reg_write
  );
    return {zero, pc_src, result_src, mem_write, alu_src, alu_control, imm_src, reg_write};
  endfunction

endpackage

// File: rtl/trace_ring.sv
// Circular entry buffer with drop-or-overwrite on full and a registered
// first-word-fall-through head.
module trace_ring #(
  parameter int ENTRY_W   = 30,
  parameter int DEPTH     = 16,
  parameter int WRAP_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [ENTRY_W-1:0]       entry_i,
  input  logic                     pop_i,
  output logic [ENTRY_W-1:0]       rd_entry_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic                     overflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]      count_q, count_d;
  logic               empty_q, full_q, ovf_q, ovf_d;
  logic [ENTRY_W-1:0] rd_q, rd_d;
  logic               pop_ok_s, wr_en_s;

  always_comb begin
    pop_ok_s = pop_i && (count_q != {CW{1'b0}});
    wr_en_s  = 1'b0;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_i) begin
      if (full_q && !pop_ok_s) begin
        ovf_d = 1'b1;
        if (WRAP_MODE != 0) begin
          wr_en_s = 1'b1;
          tail_d  = tail_q + PW'(1'b1);
          head_d  = head_q + PW'(1'b1);
        end else begin
          wr_en_s = 1'b0;
        end
      end else begin
        wr_en_s = 1'b1;
        tail_d  = tail_q + PW'(1'b1);
        if (pop_ok_s) begin
          head_d = head_q + PW'(1'b1);
        end else begin
          count_d = count_q + CW'(1'b1);
        end
      end
    end else if (pop_ok_s) begin
      head_d  = head_q + PW'(1'b1);
      count_d = count_q - CW'(1'b1);
    end else begin
      count_d = count_q;
    end
  end

  // Next head: bypass the entry being written when it lands in the head slot.
  always_comb begin
    if (count_d == {CW{1'b0}}) begin
      rd_d = {ENTRY_W{1'b0}};
    end else if (wr_en_s && (tail_q == head_d)) begin
      rd_d = entry_i;
    end else begin
      rd_d = mem_q[head_d];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[tail_q] <= entry_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= {PW{1'b0}};
      tail_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      rd_q    <= {ENTRY_W{1'b0}};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      empty_q <= (count_d == {CW{1'b0}});
      full_q  <= (count_d == CW'(DEPTH));
      ovf_q   <= ovf_d;
      rd_q    <= rd_d;
    end
  end

  assign rd_entry_o = rd_q;
  assign count_o    = count_q;
  assign empty_o    = empty_q;
  assign full_o     = full_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/ctrl_trace_buffer.sv
// Change-triggered, timestamped trace of the processor control word with a
// run limit; entries are read out through a FWFT pop port.
module ctrl_trace_buffer
  import trace_pkg::*;
#(
  parameter int TRACE_W    = TRACE_W_DEF,
  parameter int DEPTH      = 16,
  parameter int TS_W       = TS_W_DEF,
  parameter int RUN_CYCLES = 20,
  parameter int WRAP_MODE  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   capture_en,
  input  logic [TRACE_W-1:0]     trace_in,
  input  logic                   rd_en,
  output logic [TS_W-1:0]        rd_ts,
  output logic [TRACE_W-1:0]     rd_trace,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow,
  output logic                   done
);

  localparam int               ENTRY_W  = TS_W + TRACE_W;
  localparam bit               LIMIT_EN = (RUN_CYCLES != 0);
  localparam logic [TS_W-1:0]  LAST_TS  = TS_W'(RUN_CYCLES - 1);

  trace_state_e       state_q, state_d;
  logic [TS_W-1:0]    ts_q, ts_d;
  logic [TRACE_W-1:0] last_q, last_d;
  logic               done_q;
  logic               limit_hit_s, push_s;
  logic [ENTRY_W-1:0] rd_entry_s;

  assign limit_hit_s = LIMIT_EN && (ts_q == LAST_TS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARMED;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARMED: begin
        if (limit_hit_s)     state_d = DONE;
        else if (capture_en) state_d = RUN;
        else                 state_d = ARMED;
      end
      RUN: begin
        if (limit_hit_s) state_d = DONE;
        else             state_d = RUN;
      end
      DONE:    state_d = DONE;
      default: state_d = ARMED;
    endcase
  end

  always_comb begin
    push_s = 1'b0;
    case (state_q)
      ARMED:   push_s = capture_en;
      RUN:     push_s = capture_en && (trace_in != last_q);
      DONE:    push_s = 1'b0;
      default: push_s = 1'b0;
    endcase
  end

  // Timestamp saturates rather than wrapping so late entries stay ordered.
  always_comb begin
    ts_d   = ts_q;
    last_d = last_q;
    if ((state_q != DONE) && (ts_q != {TS_W{1'b1}})) begin
      ts_d = ts_q + TS_W'(1'b1);
    end else begin
      ts_d = ts_q;
    end
    if (capture_en && (state_q != DONE)) begin
      last_d = trace_in;
    end else begin
      last_d = last_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q   <= {TS_W{1'b0}};
      last_q <= {TRACE_W{1'b0}};
      done_q <= 1'b0;
    end else begin
      ts_q   <= ts_d;
      last_q <= last_d;
      done_q <= (state_d == DONE);
    end
  end

  trace_ring #(
    .ENTRY_W   (ENTRY_W),
    .DEPTH     (DEPTH),
    .WRAP_MODE (WRAP_MODE)
  ) u_ring (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push_s),
    .entry_i    ({ts_q, trace_in}),
    .pop_i      (rd_en),
    .rd_entry_o (rd_entry_s),
    .count_o    (count),
    .empty_o    (empty),
    .full_o     (full),
    .overflow_o (overflow)
  );

  assign rd_ts    = rd_entry_s[ENTRY_W-1:TRACE_W];
  assign rd_trace = rd_entry_s[TRACE_W-1:0];
  assign done     = done_q;

endmodule

// File: tb/tb_ctrl_trace_buffer.sv
// Directed bench: one default instance plus two DEPTH=4 unlimited instances
// (drop and overwrite on full) sharing clock, reset and trace stimulus.
module tb_ctrl_trace_buffer;
  import trace_pkg::*;

  logic        clk = 1'b0;
  logic        rst, capture_en;
  logic [13:0] trace_in;
  logic        rd_en_a, rd_en_b, rd_en_c;

  logic [15:0] rd_ts_a, rd_ts_b, rd_ts_c;
  logic [13:0] rd_trace_a, rd_trace_b, rd_trace_c;
  logic [4:0]  count_a;
  logic [2:0]  count_b, count_c;
  logic        empty_a, empty_b, empty_c, full_a, full_b, full_c;
  logic        ovf_a, ovf_b, ovf_c, done_a, done_b, done_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ctrl_trace_buffer #(.DEPTH(16), .RUN_CYCLES(20), .WRAP_MODE(0)) dut_a (
    .clk(clk), .rst(rst), .capture_en(capture_en), .trace_in(trace_in), .rd_en(rd_en_a),
    .rd_ts(rd_ts_a), .rd_trace(rd_trace_a), .count(count_a), .empty(empty_a),
    .full(full_a), .overflow(ovf_a), .done(done_a));

  ctrl_trace_buffer #(.DEPTH(4), .RUN_CYCLES(0), .WRAP_MODE(0)) dut_b (
    .clk(clk), .rst(rst), .capture_en(capture_en), .trace_in(trace_in), .rd_en(rd_en_b),
    .rd_ts(rd_ts_b), .rd_trace(rd_trace_b), .count(count_b), .empty(empty_b),
    .full(full_b), .overflow(ovf_b), .done(done_b));

  ctrl_trace_buffer #(.DEPTH(4), .RUN_CYCLES(0), .WRAP_MODE(1)) dut_c (
    .clk(clk), .rst(rst), .capture_en(capture_en), .trace_in(trace_in), .rd_en(rd_en_c),
    .rd_ts(rd_ts_c), .rd_trace(rd_trace_c), .count(count_c), .empty(empty_c),
    .full(full_c), .overflow(ovf_c), .done(done_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] phase_word(input int c);
    return ((c >= 3) && (c < 7)) ? 14'h0200 : 14'h0123;
  endfunction

  function automatic logic [13:0] toggle_word(input int c);
    return c[0] ? 14'h0002 : 14'h0001;
  endfunction

  initial begin
    rst = 1'b1; capture_en = 1'b0; trace_in = 14'h0000;
    rd_en_a = 1'b0; rd_en_b = 1'b0; rd_en_c = 1'b0;
    tick(); tick();
    chk("rst_count", 32'(count_a), 32'd0);
    chk("rst_empty", 32'(empty_a), 32'd1);
    chk("rst_full", 32'(full_a), 32'd0);
    chk("rst_ovf", 32'(ovf_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_rd_ts", 32'(rd_ts_a), 32'd0);
    chk("rst_rd_trace", 32'(rd_trace_a), 32'd0);

    // Constant word for 20 cycles: one entry, done after the run limit.
    rst = 1'b0; capture_en = 1'b1;
    trace_in = pack_ctrl(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 3'b010, 3'b001, 1'b1);
    for (int c = 0; c < 20; c++) begin
      if (c == 19) chk("done_before_limit", 32'(done_a), 32'd0);
      tick();
      if (c == 0) chk("first_push_latency", 32'(count_a), 32'd1);
    end
    chk("done_at_limit", 32'(done_a), 32'd1);
    chk("const_count", 32'(count_a), 32'd1);
    chk("const_ts", 32'(rd_ts_a), 32'd0);
    chk("const_word", 32'(rd_trace_a), 32'h0123);

    // Word changes at ts 3 and 7.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      trace_in = phase_word(c);
      tick();
    end
    chk("chg_count", 32'(count_a), 32'd3);
    rd_en_a = 1'b1;
    chk("pop0_ts", 32'(rd_ts_a), 32'd0);
    chk("pop0_word", 32'(rd_trace_a), 32'h0123);
    tick();
    chk("pop1_ts", 32'(rd_ts_a), 32'd3);
    chk("pop1_word", 32'(rd_trace_a), 32'h0200);
    tick();
    chk("pop2_ts", 32'(rd_ts_a), 32'd7);
    chk("pop2_word", 32'(rd_trace_a), 32'h0123);
    tick();
    chk("pop_empty", 32'(empty_a), 32'd1);
    tick();
    rd_en_a = 1'b0;
    chk("pop_when_empty_count", 32'(count_a), 32'd0);
    chk("pop_when_empty_ovf", 32'(ovf_a), 32'd0);

    // Reset with 3 entries held at ts 10.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      trace_in = phase_word(c);
      tick();
    end
    chk("mid_count_before", 32'(count_a), 32'd3);
    rst = 1'b1; tick();
    chk("mid_rst_count", 32'(count_a), 32'd0);
    chk("mid_rst_done", 32'(done_a), 32'd0);
    chk("mid_rst_empty", 32'(empty_a), 32'd1);
    chk("mid_rst_rd_ts", 32'(rd_ts_a), 32'd0);
    rst = 1'b0; trace_in = 14'h0055; tick();
    chk("rearm_count", 32'(count_a), 32'd1);
    chk("rearm_ts", 32'(rd_ts_a), 32'd0);
    chk("rearm_word", 32'(rd_trace_a), 32'h0055);

    // Toggle every cycle for 6 cycles into DEPTH=4 buffers.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      trace_in = toggle_word(c);
      tick();
    end
    capture_en = 1'b0;
    chk("tog_a_count", 32'(count_a), 32'd6);
    chk("tog_a_ovf", 32'(ovf_a), 32'd0);
    chk("drop_count", 32'(count_b), 32'd4);
    chk("drop_full", 32'(full_b), 32'd1);
    chk("drop_ovf", 32'(ovf_b), 32'd1);
    chk("wrap_count", 32'(count_c), 32'd4);
    chk("wrap_full", 32'(full_c), 32'd1);
    chk("wrap_ovf", 32'(ovf_c), 32'd1);
    rd_en_b = 1'b1; rd_en_c = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("drop_pop_ts", 32'(rd_ts_b), 32'(k));
      chk("drop_pop_word", 32'(rd_trace_b), 32'(toggle_word(k)));
      chk("wrap_pop_ts", 32'(rd_ts_c), 32'(k + 2));
      chk("wrap_pop_word", 32'(rd_trace_c), 32'(toggle_word(k + 2)));
      tick();
    end
    rd_en_b = 1'b0; rd_en_c = 1'b0;
    chk("drop_drained", 32'(empty_b), 32'd1);
    chk("wrap_drained", 32'(empty_c), 32'd1);
    chk("ovf_sticky", 32'(ovf_b), 32'd1);

    // Full buffer with a simultaneous push and pop.
    rst = 1'b1; tick(); rst = 1'b0; capture_en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      trace_in = toggle_word(c);
      tick();
    end
    chk("pp_pre_full", 32'(full_b), 32'd1);
    trace_in = toggle_word(4); rd_en_b = 1'b1; rd_en_c = 1'b1;
    tick();
    rd_en_b = 1'b0; rd_en_c = 1'b0; capture_en = 1'b0;
    chk("pp_drop_count", 32'(count_b), 32'd4);
    chk("pp_drop_ovf", 32'(ovf_b), 32'd0);
    chk("pp_drop_head_ts", 32'(rd_ts_b), 32'd1);
    chk("pp_drop_head_word", 32'(rd_trace_b), 32'h0002);
    chk("pp_wrap_count", 32'(count_c), 32'd4);
    chk("pp_wrap_ovf", 32'(ovf_c), 32'd0);
    chk("pp_wrap_head_ts", 32'(rd_ts_c), 32'd1);
    rd_en_b = 1'b1;
    tick(); tick(); tick();
    rd_en_b = 1'b0;
    chk("pp_tail_ts", 32'(rd_ts_b), 32'd4);
    chk("pp_tail_word", 32'(rd_trace_b), 32'h0001);
    chk("pp_tail_count", 32'(count_b), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
